top_level: RTL and testbench
============================

Name: top_level

Overview:
- Self-contained Hamming SECDED decoder engine ("program 2") with an internal 256x8 data memory instance `dm1`.
- After reset releases, it reads 15 16-bit codewords from `dm1` (bytes 30..59), then detects/corrects errors and classifies each word.
- It writes the 11-bit recovered message plus a 2-bit error flag back to `dm1` (bytes 0..29), then raises `done`.

Parameters:
- NWORDS, 15, number of codewords processed.
- IN_BASE, 30, byte address of first input codeword (low byte).
- OUT_BASE, 0, byte address of first output word (low byte).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  reserved start request; ignored (processing starts automatically on reset release).
- done  output  1  high when all NWORDS results are written.

Behaviour:
- Memory:
  - `dm1` holds array `core[0:255]`, 8 bits each, accessible hierarchically as `dm1.core[]` for preload and checking.
  - Combinational read, synchronous write.
  - Reset never clears `core`; contents preloaded before/during reset must survive.
- Reset (reset=0): FSM goes to RD_LO, word index i=0, done=0, holding registers cleared.
- Input word i: lo=core[IN_BASE+2i], hi=core[IN_BASE+2i+1]; codeword c={hi,lo}, bit positions 15..0.
- Codeword layout:
  - c[15:9]=d11..d5, c[8]=p8, c[7:5]=d4..d2, c[4]=p4, c[3]=d1, c[2]=p2, c[1]=p1, c[0]=p0.
  - p0 is overall even parity over bits 15..1.
- Decode (combinational from latched c):
  - s1 = XOR of c[k] for k in 1..15 with k[0]=1; s2 with k[1]=1; s4 with k[2]=1; s8 with k[3]=1.
  - syn={s8,s4,s2,s1}; P = XOR of c[15:0].
  - P=0, syn=0: no error, flag=2'b00, data from c unchanged.
  - P=1: single error; flip c[syn] (syn=0 means p0 flipped, data unaffected); flag=2'b01; data from corrected word.
  - P=0, syn!=0: double error, flag=2'b10; data extracted from uncorrected c.
- Output word i:
  - core[OUT_BASE+2i+1] = {flag[1],flag[0],3'b000,d11,d10,d9}.
  - core[OUT_BASE+2i] = {d8..d1}.
- FSM, one state per cycle:
  - RD_LO: latch lo.
  - RD_HI: latch hi.
  - WR_HI: write high result byte.
  - WR_LO: write low result byte; if i=NWORDS-1 go to DONE, else i++ and go to RD_LO.
  - DONE: no memory writes; done=1, held until reset.
- Latency: 4 cycles per word; done rises on the 60th rising edge after reset deassertion.
- Input region (30..59) and output region (0..29) are disjoint; bytes outside 0..59 are never written.
- Reset asserted mid-operation: immediate abort, done=0, i=0. Partially written outputs remain; processing restarts from word 0 on release.
- req toggling at any time has no effect.

Test Plan:
- Clean codeword, msg 11'h5A3 encoded, no flips -> output {00000,101_1010_0011} = 16'h05A3, flag 00.
- Same codeword with c[6] flipped -> output 16'h45A3 (flag 01, data corrected).
- Codeword with only c[0] (p0) flipped -> output 16'h45A3; codeword with c[8] (p8) flipped -> 16'h45A3.
- Codeword with c[3] and c[12] flipped -> high output byte bit7=1 (flag 10).
- Full 15-word random run (mixed 0/1/2 errors): all 15 result pairs match the rules; done=1 exactly 60 edges after reset release; bytes 60..255 unchanged.
- Assert reset (low) at cycle 25, release -> done low until 60 edges after release, final results correct.

Source files
------------

// File: rtl/top_level.sv
// -----------------------------------------------------------------------------
// top_level -- self-contained Hamming SECDED decoder engine ("program 2").
//
// After reset is released the engine walks NWORDS 16-bit codewords stored
// little-endian in its private 256x8 data memory (dm1) starting at byte
// IN_BASE. It decodes each one and writes {flag, 000, d11..d9} / {d8..d1}
// back starting at byte OUT_BASE, then raises done and idles.
//
// Ports:
//   clk    in   system clock, rising-edge active
//   reset  in   asynchronous, active-low reset (memory contents survive it)
//   req    in   reserved start request, intentionally ignored
//   done   out  high once all NWORDS results have been written
// -----------------------------------------------------------------------------

// Byte-wide data memory: combinational read, synchronous write, never reset,
// so contents preloaded before or during reset are kept.
module top_level_dm (
    input  logic       clk,
    input  logic       i_we,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata
);
    logic [7:0] core [0:255];

    assign o_rdata = core[i_addr];

    always_ff @(posedge clk) begin
        if (i_we)
            core[i_addr] <= i_wdata;
    end
endmodule

module top_level #(
    parameter int NWORDS   = 15,
    parameter int IN_BASE  = 30,
    parameter int OUT_BASE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic done
);
    typedef enum logic [2:0] {
        ST_RD_LO = 3'd0,
        ST_RD_HI = 3'd1,
        ST_WR_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;

    logic [15:0] w_cw;
    logic [3:0]  w_syn;
    logic        w_par;
    logic [15:0] w_fixed;
    logic [1:0]  w_flag;
    logic [7:0]  w_res_hi;
    logic [7:0]  w_res_lo;
    logic [7:0]  w_base2;
    logic [7:0]  w_addr;
    logic [7:0]  w_wdata;
    logic [7:0]  w_rdata;
    logic        w_we;
    logic        w_unused;

    // req has no function; tie it off so it is visibly unused.
    assign w_unused = req;

    // ------------------------------------------------------------------
    // Decode, purely combinational from the latched codeword.
    // Each syndrome bit is the parity of the positions whose index has
    // that bit set; the masks below enumerate those positions.
    // ------------------------------------------------------------------
    assign w_cw     = {r_hi, r_lo};
    assign w_syn[0] = ^(w_cw & 16'hAAAA);
    assign w_syn[1] = ^(w_cw & 16'hCCCC);
    assign w_syn[2] = ^(w_cw & 16'hF0F0);
    assign w_syn[3] = ^(w_cw & 16'hFF00);
    assign w_par    = ^w_cw;

    always_comb begin
        w_fixed = w_cw;
        w_flag  = 2'b00;
        if (w_par) begin
            // Odd overall parity: single error at position syn (0 = p0).
            w_fixed = w_cw ^ (16'h0001 << w_syn);
            w_flag  = 2'b01;
        end else if (w_syn != 4'd0) begin
            // Even parity with a non-zero syndrome: uncorrectable double.
            w_flag  = 2'b10;
        end
    end

    assign w_res_hi = {w_flag, 3'b000, w_fixed[15:13]};
    assign w_res_lo = {w_fixed[12:9], w_fixed[7:5], w_fixed[3]};

    // ------------------------------------------------------------------
    // Memory port steering: one address per cycle chosen by state.
    // ------------------------------------------------------------------
    assign w_base2 = {3'b000, r_idx, 1'b0};

    always_comb begin
        w_addr  = 8'(IN_BASE) + w_base2;
        w_wdata = w_res_lo;
        w_we    = 1'b0;
        case (r_state)
            ST_RD_LO: w_addr = 8'(IN_BASE) + w_base2;
            ST_RD_HI: w_addr = 8'(IN_BASE) + w_base2 + 8'd1;
            ST_WR_HI: begin
                w_addr  = 8'(OUT_BASE) + w_base2 + 8'd1;
                w_wdata = w_res_hi;
                w_we    = 1'b1;
            end
            ST_WR_LO: begin
                w_addr  = 8'(OUT_BASE) + w_base2;
                w_wdata = w_res_lo;
                w_we    = 1'b1;
            end
            default: w_we = 1'b0;
        endcase
    end

    top_level_dm dm1 (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // Sequencer: four cycles per word, done is registered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RD_LO;
            r_idx   <= 4'd0;
            r_lo    <= 8'd0;
            r_hi    <= 8'd0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                ST_RD_LO: begin
                    r_lo    <= w_rdata;
                    r_state <= ST_RD_HI;
                end
                ST_RD_HI: begin
                    r_hi    <= w_rdata;
                    r_state <= ST_WR_HI;
                end
                ST_WR_HI: r_state <= ST_WR_LO;
                ST_WR_LO: begin
                    if (r_idx == 4'(NWORDS - 1)) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_state <= ST_RD_LO;
                    end
                end
                ST_DONE:  done <= 1'b1;
                default:  r_state <= ST_RD_LO;
            endcase
        end
    end
endmodule

// File: tb/tb_top_level.sv
// Directed bench for the SECDED decoder engine. Codewords are preloaded into
// the engine's private memory, results are read back from it and compared
// against hand-derived constants and an independent reference decoder.
`timescale 1ns/1ps
module tb_top_level;
    logic clk;
    logic reset;
    logic req;
    logic done;

    int errors = 0;
    int checks = 0;

    logic [15:0] cw      [15];
    logic [15:0] exp_out [15];
    logic [7:0]  spare   [256];

    top_level u_dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoder: data bits fill non-power-of-two positions in order,
    // each pN is the parity of the positions that include N, p0 covers 15..1.
    function automatic logic [15:0] encode(input logic [10:0] m);
        logic [15:0] c;
        int j;
        c = '0;
        j = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if (pos != 1 && pos != 2 && pos != 4 && pos != 8) begin
                c[pos] = m[j];
                j++;
            end
        end
        for (int p = 1; p < 16; p = p * 2)
            for (int pos = 1; pos < 16; pos++)
                if ((pos & p) != 0) c[p] = c[p] ^ c[pos];
        c[0] = ^c[15:1];
        return c;
    endfunction

    // Reference decoder: syndrome = XOR of indices of set bits.
    function automatic logic [15:0] decode(input logic [15:0] c);
        logic [3:0]  syn;
        logic [1:0]  flag;
        logic [15:0] cc;
        logic [10:0] m;
        int j;
        syn = '0;
        for (int k = 1; k < 16; k++)
            if (c[k]) syn = syn ^ 4'(k);
        cc = c;
        if (^c) begin
            cc[syn] = ~cc[syn];
            flag = 2'b01;
        end else if (syn != 0) flag = 2'b10;
        else flag = 2'b00;
        j = 0;
        m = '0;
        for (int pos = 1; pos < 16; pos++) begin
            if (pos != 1 && pos != 2 && pos != 4 && pos != 8) begin
                m[j] = cc[pos];
                j++;
            end
        end
        return {flag, 3'b000, m};
    endfunction

    task automatic check_outputs(input string run);
        logic [15:0] got;
        for (int w = 0; w < 15; w++) begin
            got = {u_dut.dm1.core[2*w+1], u_dut.dm1.core[2*w]};
            check($sformatf("%s_word%0d", run, w), got, exp_out[w]);
            $display("%s word %0d cw=%h out=%h exp=%h", run, w, cw[w], got, exp_out[w]);
        end
    endtask

    // Counts edges after release; done must be low after edge 59, high after 60.
    task automatic run_to_done(input string run);
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            req = ~req;
            #1;
            if (n == 59) check({run, "_done_at59"}, {15'd0, done}, 16'd0);
            if (n == 60) check({run, "_done_at60"}, {15'd0, done}, 16'd1);
        end
    endtask

    initial begin
        int diffs;
        logic [15:0] c;
        int p1, p2;
        reset = 1'b0;
        req   = 1'b0;

        // Directed codewords: 11'h5A3 encodes to 16'hB42D.
        cw[0] = 16'hB42D; exp_out[0] = 16'h05A3;   // clean
        cw[1] = 16'hB46D; exp_out[1] = 16'h45A3;   // c[6] flipped
        cw[2] = 16'hB42C; exp_out[2] = 16'h45A3;   // p0 flipped
        cw[3] = 16'hB52D; exp_out[3] = 16'h45A3;   // p8 flipped
        cw[4] = 16'hA425; exp_out[4] = 16'h8522;   // c[3]+c[12] flipped
        for (int w = 5; w < 15; w++) begin
            c  = encode(11'($urandom_range(0, 2047)));
            p1 = $urandom_range(0, 15);
            p2 = (p1 + 1 + $urandom_range(0, 14)) % 16;
            if (w % 3 >= 1) c[p1] = ~c[p1];
            if (w % 3 == 2) c[p2] = ~c[p2];
            cw[w]      = c;
            exp_out[w] = decode(c);
        end

        for (int a = 0; a < 256; a++) spare[a] = 8'($urandom_range(0, 255));
        for (int a = 0; a < 256; a++) u_dut.dm1.core[a] <= spare[a];
        #1;
        for (int w = 0; w < 15; w++) begin
            u_dut.dm1.core[30+2*w]   <= cw[w][7:0];
            u_dut.dm1.core[30+2*w+1] <= cw[w][15:8];
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", {15'd0, done}, 16'd0);
        check("encode_ref", encode(11'h5A3), 16'hB42D);

        // Run 1: full pass.
        @(negedge clk);
        reset = 1'b1;
        run_to_done("run1");
        check_outputs("run1");
        diffs = 0;
        for (int a = 60; a < 256; a++)
            if (u_dut.dm1.core[a] !== spare[a]) diffs++;
        check("upper_untouched", 16'(diffs), 16'd0);
        repeat (5) @(posedge clk);
        #1;
        check("done_held", {15'd0, done}, 16'd1);

        // Run 2: abort at cycle 25, outputs poisoned beforehand.
        reset = 1'b0;
        #1;
        check("reset_clears_done", {15'd0, done}, 16'd0);
        for (int a = 0; a < 30; a++) u_dut.dm1.core[a] <= 8'hFF;
        @(negedge clk);
        reset = 1'b1;
        repeat (25) begin
            @(posedge clk);
            req = ~req;
        end
        #1;
        reset = 1'b0;
        #1;
        check("abort_done", {15'd0, done}, 16'd0);
        check("partial_kept", {u_dut.dm1.core[1], u_dut.dm1.core[0]}, exp_out[0]);
        check("unwritten_kept", {u_dut.dm1.core[29], u_dut.dm1.core[28]}, 16'hFFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_to_done("run2");
        check_outputs("run2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
